spi_master_arbiter: RTL and testbench
=====================================

SPI_MASTER_ARBITER -- requirements
Module: spi_master_arbiter

Interface
REQ-001 Parameter GAP_CYCLES, default 2: idle clk_i cycles inserted between consecutive bytes of a burst, legal range 0-15.
REQ-002 Parameter ACK_TIMEOUT, default 7: max clk_i cycles allowed between drv_start_o and drv_busy_i rising, legal range 2-15.
REQ-003 clk_i  input  1  single system clock; all logic on rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 req0_i / req1_i  input  1 each  requester 0/1 burst request; level, held until that requester's done_o pulse.
REQ-006 len0_bi / len1_bi  input  2 each  burst length minus one (0..3 -> 1..4 bytes); sampled at grant.
REQ-007 tx0_bi / tx1_bi  input  8 each  requester's current TX byte; requester advances it on tx_pop_o while granted.
REQ-008 gnt_o  output  2  one-hot grant, 2'b00 when idle.
REQ-009 tx_pop_o  output  1  one-cycle pulse: current TX byte of granted requester consumed.
REQ-010 rx_valid_o / rx_data_bo  output  1 / 8  one-cycle pulse with received byte, for the granted requester.
REQ-011 done_o  output  1  one-cycle pulse on last byte completion (same cycle as final rx_valid_o).
REQ-012 err_o  output  1  one-cycle pulse on ACK timeout.
REQ-013 drv_start_o  output  1; drv_data_bo  output  8; drv_busy_i  input  1; drv_data_bi  input  8: byte-level SPI master driver port (start, TX byte, busy, last RX byte).

Function
REQ-014 States SHALL be IDLE, ISSUE, WAIT_ACK, WAIT_DONE, GAP.
REQ-015 IDLE: if any req and drv_busy_i==0, grant per REQ-016, latch len into byte counter, go ISSUE next cycle; gnt_o valid from that cycle.
REQ-016 Arbitration round-robin: single request wins; both requesting -> requester not served last wins; last-served pointer resets to 1 (requester 0 wins first tie).
REQ-017 ISSUE: drv_start_o=1 and drv_data_bo=granted txN_bi for exactly one cycle, tx_pop_o pulses same cycle; go WAIT_ACK.
REQ-018 WAIT_ACK: stay until drv_busy_i==1, then WAIT_DONE; if ACK_TIMEOUT cycles elapse without it, pulse err_o, pulse done_o, drop grant, return IDLE (burst aborted, no rx_valid_o).
REQ-019 WAIT_DONE: on first cycle with drv_busy_i==0, pulse rx_valid_o with rx_data_bo=drv_data_bi; if byte counter==0 pulse done_o, update last-served pointer, clear gnt_o next cycle, go IDLE; else decrement counter, go GAP.
REQ-020 GAP: count GAP_CYCLES cycles (0 -> go straight to ISSUE next cycle), then ISSUE.
REQ-021 drv_start_o SHALL never assert outside ISSUE nor while drv_busy_i==1.
REQ-022 Requester dropping req mid-burst SHALL be ignored; burst runs to completion; grant SHALL never change mid-burst.
REQ-023 Request from non-granted requester during a burst SHALL be held off; served on return to IDLE (at most one cycle in IDLE between bursts).
REQ-024 rx_data_bo SHALL hold its last value between pulses.
REQ-025 Bytes within a burst are separate driver transactions; chip select toggles between bytes.

Reset
REQ-026 rst_i mid-burst SHALL abort immediately without done_o; next cycle: state IDLE, gnt_o=0, drv_start_o=0, drv_data_bo=0, tx_pop_o=0, rx_valid_o=0, rx_data_bo=0, done_o=0, err_o=0, counters 0, pointer=1.
REQ-027 Reset of this block and the driver SHALL be applied together; no wait for drv_busy_i.

Verification
REQ-028 req0_i=1, len0_bi=0, tx0_bi=8'hA5, slave loopback -> one drv_start_o pulse, drv_data_bo=8'hA5, rx_valid_o with 8'hA5 coincident with done_o, gnt_o=2'b01 then 2'b00.
REQ-029 req0_i=req1_i=1 from reset, len=1 each -> requester 0 two bytes (done_o), then requester 1 two bytes; repeat -> requester 0 first again after pointer update alternates correctly.
REQ-030 len1_bi=3, GAP_CYCLES=2 -> exactly 4 tx_pop_o, 4 rx_valid_o, one done_o on 4th; each drv_start_o exactly 2 idle cycles after the prior WAIT_DONE exit.
REQ-031 drv_busy_i tied 0, ACK_TIMEOUT=7 -> err_o and done_o pulse 7 cycles after drv_start_o, gnt_o cleared, no rx_valid_o.
REQ-032 rst_i asserted in WAIT_DONE of byte 2 of a 4-byte burst -> all outputs 0 next cycle, no done_o; subsequent req0_i served normally.
REQ-033 req0_i dropped after first byte of a 3-byte burst -> all 3 bytes transferred, done_o on third.

Source files
------------

// File: rtl/spi_master_arbiter.sv
// Two-requester round-robin arbiter in front of a byte-level SPI master driver.
// Each granted burst is issued to the driver as separate one-byte transactions.
module spi_master_arbiter #(
    parameter int unsigned GAP_CYCLES  = 2,
    parameter int unsigned ACK_TIMEOUT = 7
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       req0_i,
    input  logic       req1_i,
    input  logic [1:0] len0_bi,
    input  logic [1:0] len1_bi,
    input  logic [7:0] tx0_bi,
    input  logic [7:0] tx1_bi,
    output logic [1:0] gnt_o,
    output logic       tx_pop_o,
    output logic       rx_valid_o,
    output logic [7:0] rx_data_bo,
    output logic       done_o,
    output logic       err_o,
    output logic       drv_start_o,
    output logic [7:0] drv_data_bo,
    input  logic       drv_busy_i,
    input  logic [7:0] drv_data_bi
);

    localparam int unsigned LEN_W  = 2;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 4;
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_GAP
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          gnt_q, gnt_d;
    logic [1:0]          fin_q, fin_d;
    logic                last_q, last_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    gap_q, gap_d;
    logic [CNT_W-1:0]    ack_q, ack_d;
    logic                drv_start_q, drv_start_d;
    logic [DATA_W-1:0]   drv_data_q, drv_data_d;
    logic                tx_pop_q, tx_pop_d;
    logic                rx_valid_q, rx_valid_d;
    logic [DATA_W-1:0]   rx_data_q, rx_data_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic [1:0]          req_eff;
    logic                pick;
    logic [DATA_W-1:0]   tx_cur;

    // State and registered outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            gnt_q       <= '0;
            fin_q       <= '0;
            last_q      <= 1'b1;
            cnt_q       <= '0;
            gap_q       <= '0;
            ack_q       <= '0;
            drv_start_q <= 1'b0;
            drv_data_q  <= '0;
            tx_pop_q    <= 1'b0;
            rx_valid_q  <= 1'b0;
            rx_data_q   <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            fin_q       <= fin_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            gap_q       <= gap_d;
            ack_q       <= ack_d;
            drv_start_q <= drv_start_d;
            drv_data_q  <= drv_data_d;
            tx_pop_q    <= tx_pop_d;
            rx_valid_q  <= rx_valid_d;
            rx_data_q   <= rx_data_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        fin_d       = 2'b00;
        last_d      = last_q;
        cnt_d       = cnt_q;
        gap_d       = gap_q;
        ack_d       = ack_q;
        drv_start_d = 1'b0;
        drv_data_d  = drv_data_q;
        tx_pop_d    = 1'b0;
        rx_valid_d  = 1'b0;
        rx_data_d   = rx_data_q;
        done_d      = 1'b0;
        err_d       = 1'b0;

        // The requester that just finished still holds req during its done cycle
        req_eff = {req1_i, req0_i} & ~fin_q;
        pick    = (req_eff == 2'b11) ? ~last_q : req_eff[1];
        tx_cur  = gnt_q[1] ? tx1_bi : tx0_bi;

        case (state_q)
            S_IDLE: begin
                if (req_eff != 2'b00 && !drv_busy_i) begin
                    state_d     = S_ISSUE;
                    gnt_d       = pick ? 2'b10 : 2'b01;
                    cnt_d       = pick ? len1_bi : len0_bi;
                    drv_start_d = 1'b1;
                    tx_pop_d    = 1'b1;
                    drv_data_d  = pick ? tx1_bi : tx0_bi;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT_ACK;
                ack_d   = CNT_W'(1);
            end
            S_WAIT_ACK: begin
                if (drv_busy_i) begin
                    state_d = S_WAIT_DONE;
                end else if (ack_q == ACK_LAST) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    fin_d   = gnt_q;
                    gnt_d   = 2'b00;
                    state_d = S_IDLE;
                end else begin
                    ack_d = ack_q + CNT_W'(1);
                end
            end
            S_WAIT_DONE: begin
                if (!drv_busy_i) begin
                    rx_valid_d = 1'b1;
                    rx_data_d  = drv_data_bi;
                    if (cnt_q == '0) begin
                        done_d  = 1'b1;
                        fin_d   = gnt_q;
                        last_d  = gnt_q[1];
                        gnt_d   = 2'b00;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q - LEN_W'(1);
                        gap_d = '0;
                        if (GAP_CYCLES == 0) begin
                            state_d     = S_ISSUE;
                            drv_start_d = 1'b1;
                            tx_pop_d    = 1'b1;
                            drv_data_d  = tx_cur;
                        end else begin
                            state_d = S_GAP;
                        end
                    end
                end
            end
            S_GAP: begin
                if (gap_q != GAP_LAST) begin
                    gap_d = gap_q + CNT_W'(1);
                end else if (!drv_busy_i) begin
                    state_d     = S_ISSUE;
                    drv_start_d = 1'b1;
                    tx_pop_d    = 1'b1;
                    drv_data_d  = tx_cur;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign gnt_o       = gnt_q;
    assign tx_pop_o    = tx_pop_q;
    assign rx_valid_o  = rx_valid_q;
    assign rx_data_bo  = rx_data_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign drv_start_o = drv_start_q;
    assign drv_data_bo = drv_data_q;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Directed bench for spi_master_arbiter with a loopback SPI driver model.
module tb_spi_master_arbiter;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       req0_i, req1_i;
    logic [1:0] len0_bi, len1_bi;
    logic [7:0] tx0_bi, tx1_bi;
    logic [1:0] gnt_o;
    logic       tx_pop_o, rx_valid_o, done_o, err_o, drv_start_o;
    logic [7:0] rx_data_bo, drv_data_bo;
    logic       drv_busy_i;
    logic [7:0] drv_data_bi;

    always #5 clk = ~clk;

    spi_master_arbiter #(.GAP_CYCLES(2), .ACK_TIMEOUT(7)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req0_i(req0_i), .req1_i(req1_i),
        .len0_bi(len0_bi), .len1_bi(len1_bi),
        .tx0_bi(tx0_bi), .tx1_bi(tx1_bi),
        .gnt_o(gnt_o), .tx_pop_o(tx_pop_o),
        .rx_valid_o(rx_valid_o), .rx_data_bo(rx_data_bo),
        .done_o(done_o), .err_o(err_o),
        .drv_start_o(drv_start_o), .drv_data_bo(drv_data_bo),
        .drv_busy_i(drv_busy_i), .drv_data_bi(drv_data_bi)
    );

    int         vectors = 0;
    int         miscompares = 0;
    int         cyc = 0;
    logic [7:0] starts[$];
    int         start_cyc[$];
    logic [1:0] start_gnt[$];
    logic [7:0] rxs[$];
    int         rx_cyc[$];
    int         done_cycs[$];
    int         pops, errs, err_cyc;
    logic [1:0] done_gnt, last_gnt, drop_id;
    bit         drop_pend;
    int         busy_viol = 0;
    int         gnt_viol = 0;
    bit         slave_en, ack_wait;
    int         busy_cnt;
    logic [7:0] slave_byte;

    // One clock of observation, requester behaviour and loopback slave, at negedge
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (drop_pend) begin
            if (drop_id == 2'b01) req0_i = 1'b0;
            else if (drop_id == 2'b10) req1_i = 1'b0;
            drop_pend = 1'b0;
        end
        if (gnt_o != 2'b00) last_gnt = gnt_o;
        if (gnt_o == 2'b11) gnt_viol++;
        if (drv_start_o) begin
            if (drv_busy_i) busy_viol++;
            starts.push_back(drv_data_bo);
            start_cyc.push_back(cyc);
            start_gnt.push_back(gnt_o);
        end
        if (tx_pop_o) begin
            if (gnt_o == 2'b01) tx0_bi = tx0_bi + 8'd1;
            else if (gnt_o == 2'b10) tx1_bi = tx1_bi + 8'd1;
            pops++;
        end
        if (rx_valid_o) begin
            rxs.push_back(rx_data_bo);
            rx_cyc.push_back(cyc);
        end
        if (done_o) begin
            done_cycs.push_back(cyc);
            done_gnt  = gnt_o;
            drop_pend = 1'b1;
            drop_id   = last_gnt;
        end
        if (err_o) begin
            errs++;
            err_cyc = cyc;
        end
        if (busy_cnt != 0) begin
            busy_cnt--;
            if (busy_cnt == 0) begin
                drv_busy_i  = 1'b0;
                drv_data_bi = slave_byte;
            end
        end else if (ack_wait) begin
            ack_wait   = 1'b0;
            drv_busy_i = 1'b1;
            busy_cnt   = 3;
        end
        if (drv_start_o && slave_en) begin
            ack_wait   = 1'b1;
            slave_byte = drv_data_bo;
        end
    endtask

    task automatic clear_logs();
        starts.delete(); start_cyc.delete(); start_gnt.delete();
        rxs.delete(); rx_cyc.delete(); done_cycs.delete();
        pops = 0; errs = 0; err_cyc = 0;
    endtask

    task automatic wait_dones(input int target, input int budget, output bit ok);
        for (int i = 0; i < budget && done_cycs.size() < target; i++) tick();
        ok = (done_cycs.size() >= target);
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst_i = 1'b1; req0_i = 1'b1; req1_i = 1'b0;
        len0_bi = 2'd0; len1_bi = 2'd0; tx0_bi = 8'h00; tx1_bi = 8'h00;
        drv_busy_i = 1'b0; drv_data_bi = 8'h00;
        slave_en = 1'b1; ack_wait = 1'b0; busy_cnt = 0; drop_pend = 1'b0;
        last_gnt = 2'b00; clear_logs();
        tick(); tick(); tick();
        vectors++;
        if (gnt_o !== 2'b00) begin miscompares++; $display("FAIL reset_gnt: got %b expected 00", gnt_o); end
        vectors++;
        if ({drv_start_o, tx_pop_o, rx_valid_o, done_o, err_o} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_pulses: got %b expected 00000", {drv_start_o, tx_pop_o, rx_valid_o, done_o, err_o});
        end
        vectors++;
        if (drv_data_bo !== 8'h00) begin miscompares++; $display("FAIL reset_drv_data: got %h expected 00", drv_data_bo); end
        vectors++;
        if (rx_data_bo !== 8'h00) begin miscompares++; $display("FAIL reset_rx_data: got %h expected 00", rx_data_bo); end
        vectors++;
        if (starts.size() != 0) begin miscompares++; $display("FAIL reset_no_start: got %0d starts expected 0", starts.size()); end
        req0_i = 1'b0; rst_i = 1'b0;
        tick();
        clear_logs();
    endtask

    task automatic test_single();
        bit ok;
        len0_bi = 2'd0; tx0_bi = 8'hA5; req0_i = 1'b1;
        wait_dones(1, 100, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL single_done: got timeout expected done"); end
        vectors++;
        if (starts.size() != 1 || starts[0] !== 8'hA5) begin
            miscompares++; $display("FAIL single_start: got %0d starts first %h expected 1 of a5", starts.size(), starts[0]);
        end
        vectors++;
        if (start_gnt[0] !== 2'b01) begin miscompares++; $display("FAIL single_gnt: got %b expected 01", start_gnt[0]); end
        vectors++;
        if (rxs.size() != 1 || rxs[0] !== 8'hA5) begin
            miscompares++; $display("FAIL single_rx: got %0d rx first %h expected 1 of a5", rxs.size(), rxs[0]);
        end
        vectors++;
        if (rx_cyc[0] != done_cycs[0]) begin miscompares++; $display("FAIL single_rx_done_align: got rx %0d done %0d expected equal", rx_cyc[0], done_cycs[0]); end
        vectors++;
        if (done_gnt !== 2'b00) begin miscompares++; $display("FAIL single_gnt_clear: got %b expected 00", done_gnt); end
        for (int i = 0; i < 4; i++) tick();
        vectors++;
        if (starts.size() != 1) begin miscompares++; $display("FAIL single_no_regrant: got %0d starts expected 1", starts.size()); end
        clear_logs();
    endtask

    task automatic test_round_robin();
        bit ok;
        // Both from reset: requester 0 first
        rst_i = 1'b1; tick(); rst_i = 1'b0; tick(); clear_logs();
        len0_bi = 2'd1; len1_bi = 2'd1; tx0_bi = 8'h10; tx1_bi = 8'h20;
        req0_i = 1'b1; req1_i = 1'b1;
        wait_dones(2, 200, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL rr1_done: got timeout expected 2 dones"); end
        vectors++;
        if ({starts[0], starts[1], starts[2], starts[3]} !== 32'h1011_2021 || starts.size() != 4) begin
            miscompares++; $display("FAIL rr1_order: got %h %h %h %h expected 10 11 20 21", starts[0], starts[1], starts[2], starts[3]);
        end
        vectors++;
        if ({start_gnt[0], start_gnt[1], start_gnt[2], start_gnt[3]} !== 8'b01_01_10_10) begin
            miscompares++; $display("FAIL rr1_gnt: got %b %b %b %b expected 01 01 10 10", start_gnt[0], start_gnt[1], start_gnt[2], start_gnt[3]);
        end
        vectors++;
        if (start_cyc[2] - done_cycs[0] != 1) begin
            miscompares++; $display("FAIL rr1_handoff: got %0d cycles expected 1", start_cyc[2] - done_cycs[0]);
        end
        vectors++;
        if ({rxs[0], rxs[1], rxs[2], rxs[3]} !== 32'h1011_2021) begin
            miscompares++; $display("FAIL rr1_rx: got %h %h %h %h expected 10 11 20 21", rxs[0], rxs[1], rxs[2], rxs[3]);
        end
        clear_logs();
        // Requester 1 served last: requester 0 wins again
        tx0_bi = 8'h30; tx1_bi = 8'h40; req0_i = 1'b1; req1_i = 1'b1;
        wait_dones(2, 200, ok);
        vectors++;
        if ({starts[0], starts[1], starts[2], starts[3]} !== 32'h3031_4041 || !ok) begin
            miscompares++; $display("FAIL rr2_order: got %h %h %h %h expected 30 31 40 41", starts[0], starts[1], starts[2], starts[3]);
        end
        clear_logs();
        len0_bi = 2'd0; len1_bi = 2'd0; tx0_bi = 8'h60; req0_i = 1'b1;
        wait_dones(1, 100, ok);
        vectors++;
        if (starts.size() != 1 || starts[0] !== 8'h60 || !ok) begin
            miscompares++; $display("FAIL rr3_single: got %0d starts first %h expected 1 of 60", starts.size(), starts[0]);
        end
        clear_logs();
        // Requester 0 served last: requester 1 wins the tie
        tx0_bi = 8'h70; tx1_bi = 8'h80; req0_i = 1'b1; req1_i = 1'b1;
        wait_dones(2, 200, ok);
        vectors++;
        if ({starts[0], starts[1]} !== 16'h8070 || {start_gnt[0], start_gnt[1]} !== 4'b10_01 || !ok) begin
            miscompares++; $display("FAIL rr4_alternate: got %h/%b %h/%b expected 80/10 70/01", starts[0], start_gnt[0], starts[1], start_gnt[1]);
        end
        clear_logs();
    endtask

    task automatic test_gap_timing();
        bit ok;
        len1_bi = 2'd3; tx1_bi = 8'hC0; req1_i = 1'b1;
        wait_dones(1, 200, ok);
        vectors++;
        if (pops != 4 || rxs.size() != 4 || done_cycs.size() != 1 || !ok) begin
            miscompares++; $display("FAIL gap_counts: got pops %0d rx %0d done %0d expected 4 4 1", pops, rxs.size(), done_cycs.size());
        end
        vectors++;
        if ({rxs[0], rxs[1], rxs[2], rxs[3]} !== 32'hC0C1_C2C3) begin
            miscompares++; $display("FAIL gap_rx: got %h %h %h %h expected c0 c1 c2 c3", rxs[0], rxs[1], rxs[2], rxs[3]);
        end
        vectors++;
        if (done_cycs[0] != rx_cyc[3]) begin miscompares++; $display("FAIL gap_done_last: got done %0d rx4 %0d expected equal", done_cycs[0], rx_cyc[3]); end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (start_cyc[i+1] - rx_cyc[i] != 2) begin
                miscompares++; $display("FAIL gap_spacing%0d: got %0d idle cycles expected 2", i, start_cyc[i+1] - rx_cyc[i]);
            end
        end
        vectors++;
        if (rx_data_bo !== 8'hC3 || rx_valid_o !== 1'b0) begin
            miscompares++; $display("FAIL gap_rx_hold: got %h valid %b expected c3 valid 0", rx_data_bo, rx_valid_o);
        end
        clear_logs();
    endtask

    task automatic test_timeout();
        bit ok;
        slave_en = 1'b0;
        len0_bi = 2'd2; tx0_bi = 8'hE0; req0_i = 1'b1;
        wait_dones(1, 100, ok);
        vectors++;
        if (errs != 1 || !ok) begin miscompares++; $display("FAIL timeout_err: got %0d errs expected 1", errs); end
        vectors++;
        if (err_cyc - start_cyc[0] != 7) begin
            miscompares++; $display("FAIL timeout_latency: got %0d cycles expected 7", err_cyc - start_cyc[0]);
        end
        vectors++;
        if (done_cycs[0] != err_cyc) begin miscompares++; $display("FAIL timeout_done_align: got done %0d err %0d expected equal", done_cycs[0], err_cyc); end
        vectors++;
        if (rxs.size() != 0 || starts.size() != 1 || done_gnt !== 2'b00) begin
            miscompares++; $display("FAIL timeout_abort: got rx %0d starts %0d gnt %b expected 0 1 00", rxs.size(), starts.size(), done_gnt);
        end
        slave_en = 1'b1;
        clear_logs();
    endtask

    task automatic test_reset_midburst();
        bit ok;
        bit reached = 1'b0;
        len0_bi = 2'd3; tx0_bi = 8'h90; req0_i = 1'b1;
        for (int i = 0; i < 100 && !reached; i++) begin
            tick();
            reached = (starts.size() == 2 && drv_busy_i);
        end
        vectors++;
        if (!reached) begin miscompares++; $display("FAIL rstmid_reach: got timeout expected second byte busy"); end
        tick();
        rst_i = 1'b1; req0_i = 1'b0;
        drv_busy_i = 1'b0; ack_wait = 1'b0; busy_cnt = 0;
        tick();
        vectors++;
        if ({gnt_o, drv_start_o, tx_pop_o, rx_valid_o, done_o, err_o} !== 7'b0) begin
            miscompares++; $display("FAIL rstmid_outputs: got %b expected 0000000", {gnt_o, drv_start_o, tx_pop_o, rx_valid_o, done_o, err_o});
        end
        vectors++;
        if (rx_data_bo !== 8'h00 || drv_data_bo !== 8'h00) begin
            miscompares++; $display("FAIL rstmid_data: got rx %h drv %h expected 00 00", rx_data_bo, drv_data_bo);
        end
        rst_i = 1'b0;
        tick(); tick();
        vectors++;
        if (done_cycs.size() != 0) begin miscompares++; $display("FAIL rstmid_no_done: got %0d dones expected 0", done_cycs.size()); end
        clear_logs();
        len0_bi = 2'd0; tx0_bi = 8'h5A; req0_i = 1'b1;
        wait_dones(1, 100, ok);
        vectors++;
        if (starts.size() != 1 || starts[0] !== 8'h5A || rxs[0] !== 8'h5A || !ok) begin
            miscompares++; $display("FAIL rstmid_recover: got %0d starts %h rx %h expected 1 5a 5a", starts.size(), starts[0], rxs[0]);
        end
        clear_logs();
    endtask

    task automatic test_drop_req();
        bit ok;
        len0_bi = 2'd2; tx0_bi = 8'hB0; req0_i = 1'b1;
        for (int i = 0; i < 100 && rxs.size() < 1; i++) tick();
        req0_i = 1'b0;
        wait_dones(1, 200, ok);
        vectors++;
        if ({starts[0], starts[1], starts[2]} !== 24'hB0B1B2 || starts.size() != 3 || !ok) begin
            miscompares++; $display("FAIL drop_bytes: got %0d starts %h %h %h expected b0 b1 b2", starts.size(), starts[0], starts[1], starts[2]);
        end
        vectors++;
        if (rxs.size() != 3 || done_cycs[0] != rx_cyc[2]) begin
            miscompares++; $display("FAIL drop_done_third: got rx %0d done %0d expected 3 at %0d", rxs.size(), done_cycs[0], rx_cyc[2]);
        end
        clear_logs();
    endtask

    task automatic test_protocol();
        vectors++;
        if (busy_viol != 0) begin miscompares++; $display("FAIL start_while_busy: got %0d expected 0", busy_viol); end
        vectors++;
        if (gnt_viol != 0) begin miscompares++; $display("FAIL gnt_onehot: got %0d expected 0", gnt_viol); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_gap_timing();
        test_timeout();
        test_reset_midburst();
        test_drop_req();
        test_protocol();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
